// File: rtl/pcd_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Helpers work on 32-bit values so every channel width can reuse them (CNT_W <= 32).
package pcd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic logic [31:0] clamp_div(input logic [31:0] n);
    return (n < 32'd2) ? 32'd2 : n;
  endfunction

  // High phase is ceil(N/2), written so N = 2^CNT_W-1 cannot overflow.
  function automatic logic [31:0] high_count(input logic [31:0] n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/pcd_channel.sv
// One divider channel: counter, active/shadow divisor, pending flag, IDLE/RUN FSM.
// Optional clk_stb pulse is built when PROGRAMMABLE_CLOCK_DIVIDER_STROBE_EN is defined.
module pcd_channel
  import pcd_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             we,
  input  logic [CNT_W-1:0] div,
  output logic             pending,
  output logic             clk_out
`ifdef PROGRAMMABLE_CLOCK_DIVIDER_STROBE_EN
  ,output logic            stb
`endif
);

  localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(clamp_div(32'(DEFAULT_DIV)));

  ch_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] active, active_n;
  logic [CNT_W-1:0] shadow, shadow_n;
  logic             pending_n;
  logic             clk_out_n;
  logic             apply;
  logic [CNT_W-1:0] hi;
  logic [CNT_W-1:0] last;

  assign hi   = CNT_W'(high_count(32'(active)));
  assign last = active - CNT_W'(1);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      active  <= RESET_DIV;
      shadow  <= RESET_DIV;
      pending <= 1'b0;
      clk_out <= 1'b0;
`ifdef PROGRAMMABLE_CLOCK_DIVIDER_STROBE_EN
      stb     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      active  <= active_n;
      shadow  <= shadow_n;
      pending <= pending_n;
      clk_out <= clk_out_n;
`ifdef PROGRAMMABLE_CLOCK_DIVIDER_STROBE_EN
      // Every rise is a period start because the low phase is at least one cycle.
      stb     <= clk_out_n & ~clk_out;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    active_n  = active;
    shadow_n  = shadow;
    pending_n = pending;
    clk_out_n = clk_out;
    apply     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n     = '0;
        clk_out_n = 1'b0;
        apply     = pending;
        if (en) begin
          state_n   = RUN;
          clk_out_n = 1'b1;
        end
      end
      RUN: begin
        if (cnt == last) begin
          cnt_n = '0;
          apply = pending;
          if (en) begin
            clk_out_n = 1'b1;
          end else begin
            state_n   = IDLE;
            clk_out_n = 1'b0;
          end
        end else begin
          cnt_n     = cnt + CNT_W'(1);
          clk_out_n = (cnt_n < hi);
        end
      end
      default: state_n = IDLE;
    endcase
    if (apply) begin
      active_n  = shadow;
      pending_n = 1'b0;
    end
    // A write wins over a same-cycle apply, so it waits for the next boundary.
    if (we) begin
      shadow_n  = CNT_W'(clamp_div(32'(div)));
      pending_n = 1'b1;
    end
  end

endmodule

// File: rtl/programmable_clock_divider.sv
// Multi-channel programmable clock divider: decodes divisor writes and instantiates channels.
// Define PROGRAMMABLE_CLOCK_DIVIDER_STROBE_EN to add the per-channel clk_stb output.
module programmable_clock_divider
  import pcd_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           ch_en,
  input  logic                        cfg_we,
  input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]            cfg_div,
  output logic [NUM_CH-1:0]           cfg_pending,
  output logic [NUM_CH-1:0]           clk_out
`ifdef PROGRAMMABLE_CLOCK_DIVIDER_STROBE_EN
  ,output logic [NUM_CH-1:0]          clk_stb
`endif
);

  localparam int CH_IDX_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] we_ch;

  // Selects at or above NUM_CH match no channel, so such writes are dropped.
  always_comb begin
    we_ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we && (cfg_ch == CH_IDX_W'(i))) we_ch[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    pcd_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in  (clk_in),
      .reset   (reset),
      .en      (ch_en[g]),
      .we      (we_ch[g]),
      .div     (cfg_div),
      .pending (cfg_pending[g]),
      .clk_out (clk_out[g])
`ifdef PROGRAMMABLE_CLOCK_DIVIDER_STROBE_EN
      ,.stb    (clk_stb[g])
`endif
    );
  end

endmodule
